// File: rtl/riscv_dbg_bridge.sv
// Host-side debug port sequencer: turns host read/write/halt/resume commands into
// strobe/ack accesses on the debug unit bus and owns the core halt (stall) state.
module riscv_dbg_bridge #(
  parameter int XLEN          = 32,
  parameter int DBG_ADDR_SIZE = 16,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [DBG_ADDR_SIZE-1:0] cmd_addr,
  input  logic [XLEN-1:0]          cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_data,
  output logic                     rsp_err,
  output logic                     halted,
  output logic                     bp_event,
  output logic                     dbg_stall,
  output logic                     dbg_strb,
  output logic                     dbg_we,
  output logic [DBG_ADDR_SIZE-1:0] dbg_addr,
  output logic [XLEN-1:0]          dbg_dati,
  input  logic [XLEN-1:0]          dbg_dato,
  input  logic                     dbg_ack,
  input  logic                     dbg_bp
);

  localparam int DU_ADDR_SIZE = 12;
  localparam int BANK_W       = DBG_ADDR_SIZE - DU_ADDR_SIZE;
  localparam logic [BANK_W-1:0] DBG_INTERNAL = '0;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_HALT, OP_RESUME} op_t;

  state_t      state, state_nxt;
  op_t         op;
  logic        acc, is_rw, reject, halt_acc, resume_acc, timeout;
  logic        halted_nxt, we_r;
  logic [7:0]  cnt;

  assign op         = op_t'(cmd_op);
  assign acc        = cmd_valid && (state == IDLE);
  assign is_rw      = (op == OP_READ) || (op == OP_WRITE);
  // GPR/CSR banks are only acked by the debug unit while the core is stalled
  assign reject     = is_rw && (cmd_addr[DBG_ADDR_SIZE-1 -: BANK_W] != DBG_INTERNAL) && !halted;
  assign halt_acc   = acc && (op == OP_HALT);
  assign resume_acc = acc && (op == OP_RESUME);
  assign timeout    = (cnt == 8'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = (is_rw && !reject) ? ACCESS : RESP;
      ACCESS:  if (dbg_ack || timeout) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE) && !rst;
    rsp_valid = (state == RESP);
    dbg_strb  = (state == ACCESS);
    dbg_we    = dbg_strb && we_r;
    dbg_stall = halted;
  end

  // A resume applied together with a breakpoint leaves the core halted
  always_comb begin
    halted_nxt = halted;
    if (halt_acc)        halted_nxt = 1'b1;
    else if (resume_acc) halted_nxt = dbg_bp;
    else if (dbg_bp)     halted_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted   <= 1'b0;
      bp_event <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      dbg_addr <= '0;
      dbg_dati <= '0;
      we_r     <= 1'b0;
      cnt      <= '0;
    end else begin
      halted   <= halted_nxt;
      bp_event <= dbg_bp && ((!halted && !halt_acc) || resume_acc);
      if (acc) begin
        case (op)
          OP_READ, OP_WRITE: begin
            if (reject) begin
              rsp_err  <= 1'b1;
              rsp_data <= '0;
            end else begin
              dbg_addr <= cmd_addr;
              dbg_dati <= cmd_data;
              we_r     <= (op == OP_WRITE);
              cnt      <= '0;
              rsp_err  <= 1'b0;
            end
          end
          OP_HALT: begin
            rsp_data <= XLEN'(1);
            rsp_err  <= 1'b0;
          end
          default: begin
            rsp_data <= XLEN'(dbg_bp);
            rsp_err  <= 1'b0;
          end
        endcase
      end
      if (state == ACCESS) begin
        if (dbg_ack) begin
          rsp_data <= we_r ? '0 : dbg_dato;
          rsp_err  <= 1'b0;
        end else if (timeout) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_dbg_bridge.sv
// Scoreboarded bench for riscv_dbg_bridge: a behavioural debug unit with memory answers
// strobes; expected responses come from a command-level model of the bridge rules.
module tb_riscv_dbg_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr, dbg_addr;
  logic [31:0] cmd_data, rsp_data, dbg_dati, dbg_dato;
  logic        halted, bp_event, dbg_stall, dbg_strb, dbg_we, dbg_ack, dbg_bp;

  riscv_dbg_bridge #(.XLEN(32), .DBG_ADDR_SIZE(16), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .halted(halted), .bp_event(bp_event),
    .dbg_stall(dbg_stall), .dbg_strb(dbg_strb), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_dati(dbg_dati), .dbg_dato(dbg_dato), .dbg_ack(dbg_ack), .dbg_bp(dbg_bp)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] data; logic err; logic hlt;} rsp_t;
  typedef struct {logic [15:0] addr; logic we; logic [31:0] data; int lat;} acc_t;

  rsp_t        exp_q[$];
  acc_t        acc_q[$];
  logic [31:0] m_mem [logic [15:0]];
  logic [31:0] du_mem[logic [15:0]];
  bit          m_halted = 1'b0;
  bit          hold_low = 1'b0;
  bit          rst_abort = 1'b0;
  int          checks = 0;
  int          fails = 0;
  int          bp_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {a ^ 16'hA5A5, a};
  endfunction

  // Command-level reference: bank rule, halt ownership, timeout by ack latency
  task automatic predict(input logic [1:0] op, input logic [15:0] a, input logic [31:0] d,
                         input int lat, input bit bp);
    rsp_t r;
    acc_t x;
    r.err = 1'b0;
    r.data = '0;
    if (op[1] == 1'b0) begin
      if (a[15:12] != 4'h0 && !m_halted) begin
        r.err = 1'b1;
      end else begin
        x.addr = a; x.we = op[0]; x.data = d; x.lat = lat;
        acc_q.push_back(x);
        if (lat > TO) r.err = 1'b1;
        else if (op[0]) m_mem[a] = d;
        else r.data = m_mem.exists(a) ? m_mem[a] : dflt(a);
      end
    end else begin
      m_halted = (op == 2'b10) ? 1'b1 : bp;
      r.data = {31'd0, m_halted};
    end
    r.hlt = m_halted;
    exp_q.push_back(r);
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [31:0] d,
                       input int lat, input bit bp);
    int n;
    predict(op, a, d, lat, bp);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; dbg_bp = bp;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      chk("accept_timeout", 64'd1, 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $fatal(1, "command never accepted");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; dbg_bp = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  // Host response side
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Behavioural debug unit: acks on the lat-th strobe cycle, noise ack while idle
  initial begin
    acc_t a;
    int   k;
    bit   acked;
    dbg_ack = 1'b0; dbg_dato = '0;
    forever begin
      @(posedge clk); #1;
      if (dbg_strb && !rst) begin
        dbg_ack = 1'b0;
        if (acc_q.size() == 0) begin
          chk("unexpected_strb", 64'd1, 64'd0);
          while (dbg_strb) begin @(posedge clk); #1; end
        end else begin
          a = acc_q.pop_front();
          k = 1;
          acked = 1'b0;
          while (dbg_strb && !acked) begin
            chk("strb_addr", dbg_addr, a.addr);
            chk("strb_we", dbg_we, a.we);
            if (a.we) chk("strb_dati", dbg_dati, a.data);
            if (k == a.lat) begin
              dbg_ack = 1'b1;
              if (a.we) begin
                dbg_dato = $urandom;
                du_mem[dbg_addr] = dbg_dati;
              end else begin
                dbg_dato = du_mem.exists(dbg_addr) ? du_mem[dbg_addr] : dflt(dbg_addr);
              end
              @(posedge clk); #1;
              dbg_ack = 1'b0;
              chk("strb_after_ack", dbg_strb, 1'b0);
              chk("rsp_after_ack", rsp_valid, 1'b1);
              acked = 1'b1;
            end else begin
              @(posedge clk); #1;
              k++;
            end
          end
          if (!acked && !rst_abort) chk("timeout_cycles", k - 1, TO);
        end
      end else begin
        dbg_ack = ($urandom_range(0, 3) == 0);
        dbg_dato = $urandom;
      end
    end
  end

  // Response monitor / scoreboard
  logic        seen = 1'b0;
  logic [32:0] held;
  always @(negedge clk) begin
    rsp_t r;
    if (bp_event) bp_cnt++;
    if (rst || !rsp_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        r = exp_q.pop_front();
        chk("rsp_data", rsp_data, r.data);
        chk("rsp_err", rsp_err, r.err);
        chk("rsp_halted", halted, r.hlt);
        chk("dbg_stall", dbg_stall, r.hlt);
      end
      held = {rsp_err, rsp_data};
      seen = 1'b1;
      chk("cmd_ready_in_rsp", cmd_ready, 1'b0);
    end else begin
      chk("rsp_stable", {rsp_err, rsp_data}, held);
      chk("cmd_ready_in_rsp", cmd_ready, 1'b0);
    end
  end

  initial begin
    int n;
    int pre;
    logic [1:0] op;
    logic [15:0] a;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; dbg_bp = 1'b0;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", cmd_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_strb", dbg_strb, 1'b0);
    chk("rst_addr", dbg_addr, 16'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);

    // halt command
    issue(2'b10, 16'h0, 32'h0, 0, 1'b0);
    chk("halt_next_cycle", halted, 1'b1);
    chk("halt_stall", dbg_stall, 1'b1);
    drain();
    chk("halt_no_bp_event", bp_cnt, 0);

    // halted GPR write with 3-cycle ack, then read back; ack at exact timeout boundary
    issue(2'b01, 16'h1005, 32'hDEADBEEF, 3, 1'b0);
    issue(2'b00, 16'h1005, 32'h0, 2, 1'b0);
    issue(2'b00, 16'h1005, 32'h0, TO, 1'b0);
    drain();

    // running: CSR bank rejected, internal bank served
    issue(2'b11, 16'h0, 32'h0, 0, 1'b0);
    issue(2'b00, 16'h2003, 32'h0, 1, 1'b0);
    issue(2'b00, 16'h0010, 32'h0, 2, 1'b0);
    // timeout then normal command
    issue(2'b00, 16'h0020, 32'h0, TO + 5, 1'b0);
    issue(2'b01, 16'h0021, 32'h12345678, 1, 1'b0);
    issue(2'b00, 16'h0021, 32'h0, 4, 1'b0);
    drain();

    // breakpoint while running, while halted, and alongside resume
    pre = bp_cnt;
    @(posedge clk); #1; dbg_bp = 1'b1;
    @(posedge clk); #1; dbg_bp = 1'b0;
    m_halted = 1'b1;
    chk("bp_halts", halted, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_single_pulse", bp_cnt - pre, 1);
    @(posedge clk); #1; dbg_bp = 1'b1;
    @(posedge clk); #1; dbg_bp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_when_halted", bp_cnt - pre, 1);
    issue(2'b11, 16'h0, 32'h0, 0, 1'b1);
    chk("resume_bp_keeps_halt", halted, 1'b1);
    drain();
    chk("resume_bp_pulse", bp_cnt - pre, 2);
    issue(2'b11, 16'h0, 32'h0, 0, 1'b0);
    chk("resume_clears", halted, 1'b0);
    drain();

    // host back-pressure
    hold_low = 1'b1;
    issue(2'b00, 16'h0021, 32'h0, 2, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    repeat (10) @(posedge clk);
    #1;
    chk("stall_rsp_valid", rsp_valid, 1'b1);
    chk("stall_cmd_ready", cmd_ready, 1'b0);
    hold_low = 1'b0;
    drain();

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      n = $urandom_range(0, 9);
      op = (n < 4) ? 2'b00 : (n < 8) ? 2'b01 : (n == 8) ? 2'b10 : 2'b11;
      a = {4'($urandom_range(0, 2)), 8'h00, 4'($urandom_range(0, 7))};
      issue(op, a, $urandom, $urandom_range(1, TO + 2), 1'b0);
    end
    drain();

    // reset in the middle of an access
    issue(2'b00, 16'h0003, 32'h0, TO + 50, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_abort = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_mid_strb", dbg_strb, 1'b0);
    chk("rst_mid_ready", cmd_ready, 1'b0);
    exp_q.delete();
    acc_q.delete();
    m_halted = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", cmd_ready, 1'b1);
    chk("post_rst_valid", rsp_valid, 1'b0);
    repeat (2) @(posedge clk);
    rst_abort = 1'b0;
    issue(2'b00, 16'h0003, 32'h0, 3, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    chk("global_timeout", 64'd1, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "simulation time limit");
  end

endmodule
